// File: rtl/dice_game_pkg.sv
// Shared types and helpers for the dice race game: color codes, the turn-scheduler
// state encoding and the color-to-move mapping.
package dice_game_pkg;

  localparam int unsigned POS_W   = 5;
  localparam int unsigned COLOR_W = 2;
  localparam int unsigned MOVE_W  = 3;

  localparam logic [COLOR_W-1:0] COLOR_NONE  = 2'b00;
  localparam logic [COLOR_W-1:0] COLOR_RED   = 2'b01;
  localparam logic [COLOR_W-1:0] COLOR_GREEN = 2'b10;
  localparam logic [COLOR_W-1:0] COLOR_BLUE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_WHITE = 3'd1,
    ST_WAIT_ROLL  = 3'd2,
    ST_MOVE       = 3'd3,
    ST_WAIT_CLEAR = 3'd4,
    ST_NEXT       = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // Squares advanced for a color; the per-color amounts are supplied by the caller.
  function automatic logic [MOVE_W-1:0] color_to_move(
    input logic [COLOR_W-1:0] color,
    input logic [MOVE_W-1:0]  move_red,
    input logic [MOVE_W-1:0]  move_green,
    input logic [MOVE_W-1:0]  move_blue
  );
    logic [MOVE_W-1:0] amt;
    case (color)
      COLOR_RED:   amt = move_red;
      COLOR_GREEN: amt = move_green;
      COLOR_BLUE:  amt = move_blue;
      default:     amt = '0;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/dice_turn_timer.sv
// Roll-wait timer: counts while enabled, flags expiry at LIMIT-1; LIMIT of 0 disables it.
module dice_turn_timer #(
  parameter logic [31:0] LIMIT = 32'd500_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               count <= '0;
    else if (clear)                          count <= '0;
    else if (enable && (LIMIT != 32'd0))     count <= count + 32'd1;
  end

  assign expire_c = enable && (LIMIT != 32'd0) && (count == LIMIT - 32'd1);

endmodule

// File: rtl/dice_turn_scheduler.sv
// Dice race turn sequencer: waits for a clear board, takes one roll, moves the
// current player, waits for the dice to be removed, then passes the turn.
module dice_turn_scheduler
  import dice_game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 4,
  parameter int unsigned BOARD_LEN      = 20,
  parameter int unsigned MOVE_RED       = 1,
  parameter int unsigned MOVE_GREEN     = 2,
  parameter int unsigned MOVE_BLUE      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COLOR_W-1:0]   stable_color,
  input  logic                 result_ready,
  input  logic                 turn_end,
  input  logic                 current_state_white,
  output logic [1:0]           cur_player,
  output logic [4*POS_W-1:0]   positions,
  output logic                 move_valid,
  output logic [MOVE_W-1:0]    move_amount,
  output logic                 turn_timeout,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic [2:0]           state_dbg
);

  localparam int unsigned POSV_W = 4 * POS_W;

  state_t               state, state_n;
  logic [1:0]           cur_player_n, winner_n;
  logic [POSV_W-1:0]    positions_n;
  logic                 move_valid_n, turn_timeout_n, game_over_n;
  logic [MOVE_W-1:0]    move_amount_n;
  logic                 timer_en_c, timer_expire_c;
  logic [POS_W-1:0]     cur_pos_c, sat_pos_c;
  logic [POS_W:0]       sum_c;

  assign timer_en_c = (state == ST_WAIT_ROLL);

  dice_turn_timer #(.LIMIT(32'(TIMEOUT_CYCLES))) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!timer_en_c),
    .enable   (timer_en_c),
    .expire_c (timer_expire_c)
  );

  // Saturating 6-bit add of the current player's position and the latched roll.
  assign cur_pos_c = positions[int'(cur_player)*POS_W +: POS_W];
  assign sum_c     = 6'(cur_pos_c) + 6'(move_amount);
  assign sat_pos_c = (sum_c >= 6'(BOARD_LEN)) ? 5'(BOARD_LEN) : sum_c[POS_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur_player   <= '0;
      positions    <= '0;
      move_valid   <= 1'b0;
      move_amount  <= '0;
      turn_timeout <= 1'b0;
      game_over    <= 1'b0;
      winner       <= '0;
    end else begin
      state        <= state_n;
      cur_player   <= cur_player_n;
      positions    <= positions_n;
      move_valid   <= move_valid_n;
      move_amount  <= move_amount_n;
      turn_timeout <= turn_timeout_n;
      game_over    <= game_over_n;
      winner       <= winner_n;
    end
  end

  always_comb begin
    state_n        = state;
    cur_player_n   = cur_player;
    positions_n    = positions;
    move_valid_n   = 1'b0;
    move_amount_n  = move_amount;
    turn_timeout_n = 1'b0;
    game_over_n    = game_over;
    winner_n       = winner;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          positions_n  = '0;
          cur_player_n = '0;
          winner_n     = '0;
          game_over_n  = 1'b0;
          state_n      = ST_WAIT_WHITE;
        end
      end
      ST_WAIT_WHITE: begin
        if (current_state_white) state_n = ST_WAIT_ROLL;
      end
      // A valid roll takes priority over a coincident timeout.
      ST_WAIT_ROLL: begin
        if (result_ready && (stable_color != COLOR_NONE)) begin
          move_amount_n = color_to_move(stable_color, 3'(MOVE_RED), 3'(MOVE_GREEN), 3'(MOVE_BLUE));
          state_n       = ST_MOVE;
        end else if (timer_expire_c) begin
          turn_timeout_n = 1'b1;
          state_n        = ST_NEXT;
        end
      end
      ST_MOVE: begin
        positions_n[int'(cur_player)*POS_W +: POS_W] = sat_pos_c;
        move_valid_n = 1'b1;
        if (sat_pos_c == 5'(BOARD_LEN)) begin
          winner_n    = cur_player;
          game_over_n = 1'b1;
          state_n     = ST_DONE;
        end else begin
          state_n = ST_WAIT_CLEAR;
        end
      end
      ST_WAIT_CLEAR: begin
        if (turn_end) state_n = ST_NEXT;
      end
      ST_NEXT: begin
        cur_player_n = (cur_player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_player + 2'd1;
        state_n      = ST_WAIT_WHITE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Directed bench for dice_turn_scheduler: 3 players, board of 20, 10-cycle roll timeout.
module tb_dice_turn_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  stable_color;
  logic        result_ready;
  logic        turn_end;
  logic        current_state_white;
  logic [1:0]  cur_player;
  logic [19:0] positions;
  logic        move_valid;
  logic [2:0]  move_amount;
  logic        turn_timeout;
  logic        game_over;
  logic [1:0]  winner;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  dice_turn_scheduler #(
    .NUM_PLAYERS    (3),
    .BOARD_LEN      (20),
    .MOVE_RED       (1),
    .MOVE_GREEN     (2),
    .MOVE_BLUE      (3),
    .TIMEOUT_CYCLES (32'd10)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .stable_color        (stable_color),
    .result_ready        (result_ready),
    .turn_end            (turn_end),
    .current_state_white (current_state_white),
    .cur_player          (cur_player),
    .positions           (positions),
    .move_valid          (move_valid),
    .move_amount         (move_amount),
    .turn_timeout        (turn_timeout),
    .game_over           (game_over),
    .winner              (winner),
    .state_dbg           (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rr(input logic [1:0] color);
    stable_color = color;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    stable_color = 2'b00;
  endtask

  task automatic pulse_te();
    turn_end = 1'b1;
    tick();
    turn_end = 1'b0;
  endtask

  // From the first cycle of WAIT_ROLL: roll, move, clear, pass; ends in the next WAIT_ROLL.
  task automatic do_turn(input logic [1:0] color);
    pulse_rr(color);
    tick();
    pulse_te();
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   32'(state_dbg),    32'd0);
    check({tag, "_pos"},     32'(positions),    32'd0);
    check({tag, "_cur"},     32'(cur_player),   32'd0);
    check({tag, "_mv"},      32'(move_valid),   32'd0);
    check({tag, "_amt"},     32'(move_amount),  32'd0);
    check({tag, "_to"},      32'(turn_timeout), 32'd0);
    check({tag, "_go"},      32'(game_over),    32'd0);
    check({tag, "_win"},     32'(winner),       32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stable_color = 2'b00; result_ready = 1'b0;
    turn_end = 1'b0; current_state_white = 1'b0;
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("idle_state", 32'(state_dbg), 32'd0);

    // Start; board not yet white, so a RED roll must be dropped.
    start = 1'b1; tick(); start = 1'b0;
    check("ww_state", 32'(state_dbg), 32'd1);
    pulse_rr(2'b01);
    tick();
    check("ww_red_state", 32'(state_dbg), 32'd1);
    check("ww_red_pos", 32'(positions), 32'd0);
    check("ww_red_amt", 32'(move_amount), 32'd0);

    current_state_white = 1'b1;
    tick();
    check("wr_state", 32'(state_dbg), 32'd2);
    pulse_rr(2'b00);
    check("none_state", 32'(state_dbg), 32'd2);

    // GREEN roll: MOVE next cycle, update + move_valid the cycle after.
    pulse_rr(2'b10);
    check("green_move_state", 32'(state_dbg), 32'd3);
    check("green_amt", 32'(move_amount), 32'd2);
    check("green_mv_early", 32'(move_valid), 32'd0);
    tick();
    check("green_mv", 32'(move_valid), 32'd1);
    check("green_pos", 32'(positions), 32'd2);
    check("green_wc_state", 32'(state_dbg), 32'd4);
    tick();
    check("green_mv_1cyc", 32'(move_valid), 32'd0);

    // Second roll while waiting for clear must not move; white alone must not advance.
    pulse_rr(2'b11);
    check("wc_blue_state", 32'(state_dbg), 32'd4);
    check("wc_blue_pos", 32'(positions), 32'd2);
    check("wc_blue_mv", 32'(move_valid), 32'd0);

    pulse_te();
    check("next_state", 32'(state_dbg), 32'd5);
    check("next_cur_old", 32'(cur_player), 32'd0);
    tick();
    check("p1_cur", 32'(cur_player), 32'd1);
    check("p1_ww_state", 32'(state_dbg), 32'd1);
    tick();
    check("p1_wr_state", 32'(state_dbg), 32'd2);

    // Player 1 BLUE -> 3, then player 2 times out.
    do_turn(2'b11);
    check("p1_pos", 32'(positions), 32'd2 | (32'd3 << 5));
    check("p2_cur", 32'(cur_player), 32'd2);
    repeat (9) tick();
    check("to_not_yet", 32'(turn_timeout), 32'd0);
    check("to_wr_state", 32'(state_dbg), 32'd2);
    tick();
    check("to_pulse", 32'(turn_timeout), 32'd1);
    check("to_next_state", 32'(state_dbg), 32'd5);
    tick();
    check("to_pulse_1cyc", 32'(turn_timeout), 32'd0);
    check("wrap_cur", 32'(cur_player), 32'd0);
    check("p2_unmoved", 32'(positions[14:10]), 32'd0);
    check("p3_unused", 32'(positions[19:15]), 32'd0);

    // Roll on the expiry cycle wins over the timeout.
    tick();
    repeat (9) tick();
    pulse_rr(2'b10);
    check("race_to", 32'(turn_timeout), 32'd0);
    check("race_state", 32'(state_dbg), 32'd3);
    tick();
    check("race_mv", 32'(move_valid), 32'd1);
    check("race_pos0", 32'(positions[4:0]), 32'd4);
    pulse_te(); tick(); tick();

    // Build player 1 to 7 and reset inside WAIT_CLEAR.
    do_turn(2'b01);
    do_turn(2'b11);
    do_turn(2'b11);
    pulse_rr(2'b11);
    tick();
    check("pre_rst_state", 32'(state_dbg), 32'd4);
    check("pre_rst_pos", 32'(positions), 32'd3303);
    reset = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(state_dbg), 32'd0);

    // Fresh game after reset.
    start = 1'b1; tick(); start = 1'b0;
    check("restart_ww", 32'(state_dbg), 32'd1);
    tick();
    check("restart_wr", 32'(state_dbg), 32'd2);

    for (int r = 0; r < 6; r++) begin
      do_turn(2'b11);
      do_turn(2'b01);
      do_turn(2'b01);
      if (r == 0) begin
        check("round0_cur", 32'(cur_player), 32'd0);
        check("round0_pos", 32'(positions), 32'd3 | (32'd1 << 5) | (32'd1 << 10));
      end
    end
    do_turn(2'b01);
    do_turn(2'b01);
    do_turn(2'b01);
    check("pre_win_pos", 32'(positions), 32'd7411);
    check("pre_win_cur", 32'(cur_player), 32'd0);

    // Player 0 at 19 rolls BLUE: saturate at 20 and win.
    pulse_rr(2'b11);
    check("win_move_state", 32'(state_dbg), 32'd3);
    check("win_go_early", 32'(game_over), 32'd0);
    tick();
    check("win_pos", 32'(positions), 32'd7412);
    check("win_mv", 32'(move_valid), 32'd1);
    check("win_go", 32'(game_over), 32'd1);
    check("win_winner", 32'(winner), 32'd0);
    check("win_state", 32'(state_dbg), 32'd6);

    pulse_rr(2'b10);
    pulse_te();
    tick();
    check("done_state", 32'(state_dbg), 32'd6);
    check("done_pos", 32'(positions), 32'd7412);
    check("done_mv", 32'(move_valid), 32'd0);
    check("done_go", 32'(game_over), 32'd1);

    start = 1'b1; tick(); start = 1'b0;
    check("done_start_state", 32'(state_dbg), 32'd1);
    check("done_start_pos", 32'(positions), 32'd0);
    check("done_start_go", 32'(game_over), 32'd0);
    check("done_start_cur", 32'(cur_player), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
